// File: rtl/nfi_engine.sv
// rtl/nfi_engine.sv - toroidal B3/S23 next-field engine, one shadow row per clock
module nfi_engine #(
  parameter int ROWS = 16,
  parameter int COLS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_go,
  input  logic                    i_wr_en,
  input  logic [$clog2(ROWS)-1:0] i_wr_row,
  input  logic [COLS-1:0]         i_wr_data,
  input  logic [$clog2(ROWS)-1:0] i_rd_row,
  output logic [COLS-1:0]         o_rd_data,
  output logic                    o_busy,
  output logic                    o_done
);
  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

  state_t          state;
  logic [RW-1:0]   row_cnt;
  logic [COLS-1:0] cur [ROWS];
  logic [COLS-1:0] nxt [ROWS];
  logic [RW-1:0]   row_up;
  logic [RW-1:0]   row_dn;
  logic [COLS-1:0] calc_row;

  // Column wrap is done by rotating whole rows so every bit index stays a loop constant.
  function automatic logic [COLS-1:0] life_row(input logic [COLS-1:0] up,
                                               input logic [COLS-1:0] mid,
                                               input logic [COLS-1:0] dn);
    logic [COLS-1:0] res;
    logic [COLS-1:0] ul, ur, ml, mr, dl, dr;
    logic [3:0]      nb;
    ul = {up[COLS-2:0], up[COLS-1]};
    ur = {up[0], up[COLS-1:1]};
    ml = {mid[COLS-2:0], mid[COLS-1]};
    mr = {mid[0], mid[COLS-1:1]};
    dl = {dn[COLS-2:0], dn[COLS-1]};
    dr = {dn[0], dn[COLS-1:1]};
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      nb = 4'(ul[c]) + 4'(up[c]) + 4'(ur[c]) + 4'(ml[c]) +
           4'(mr[c]) + 4'(dl[c]) + 4'(dn[c]) + 4'(dr[c]);
      res[c] = (nb == 4'd3) || (mid[c] && nb == 4'd2);
    end
    return res;
  endfunction

  always_comb begin
    row_up   = (row_cnt == '0) ? LAST_ROW : row_cnt - 1'b1;
    row_dn   = (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
    calc_row = life_row(cur[row_up], cur[row_cnt], cur[row_dn]);
  end

  assign o_rd_data = cur[i_rd_row];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      row_cnt <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        cur[r] <= '0;
        nxt[r] <= '0;
      end
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          // A write on the same edge as go wins and the go is dropped.
          if (i_wr_en) begin
            cur[i_wr_row] <= i_wr_data;
          end else if (i_go) begin
            state   <= CALC;
            row_cnt <= '0;
            o_busy  <= 1'b1;
          end
        end
        CALC: begin
          nxt[row_cnt] <= calc_row;
          if (row_cnt == LAST_ROW) begin
            row_cnt <= '0;
            state   <= COMMIT;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        COMMIT: begin
          for (int r = 0; r < ROWS; r++) cur[r] <= nxt[r];
          o_busy <= 1'b0;
          o_done <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
